// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial lookahead adder/subtractor.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NIB_BITS = 4;

  // Counter width for n nibbles; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead slice with flattened carry equations.
module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1, c2, c3;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c1 = g[0] | (p[0] & cin_i);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin_i);
  assign cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin_i);

  assign s_o = p ^ {c3, c2, c1, cin_i};

endmodule

// File: rtl/cla_serial_addsub.sv
// Multi-cycle add/subtract: one lookahead nibble per cycle, LSB first, carry registered
// between nibbles, with valid/ready handshakes on both the operand and result sides.
module cla_serial_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NIB = WIDTH / NIB_BITS;
  localparam int unsigned CW  = clog2(NIB);
  localparam int unsigned IW  = CW + 2;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_out_q;
  logic               overflow_q;

  logic               accept;
  logic               last_nib;
  logic [IW-1:0]      bit_idx;
  logic [NIB_BITS-1:0] sum_nib;
  logic               slice_cout;

  assign accept   = in_valid & in_ready;
  assign last_nib = (cnt_q == CW'(NIB - 1));
  assign bit_idx  = {cnt_q, 2'b00};

  // Single slice shared across all nibbles, indexed by the counter.
  cla4_slice u_slice (
    .a_i    (a_q[bit_idx +: NIB_BITS]),
    .b_i    (b_q[bit_idx +: NIB_BITS]),
    .cin_i  (carry_q),
    .s_o    (sum_nib),
    .cout_o (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) & ~rst;
    out_valid = (state_q == DONE);
    result    = result_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
  end

  // Subtraction is a + ~b + 1: B is inverted on capture and the carry seeded with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      result_q[bit_idx +: NIB_BITS] <= sum_nib;
      carry_q <= slice_cout;
      if (last_nib) begin
        carry_out_q <= slice_cout;
        overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                       (sum_nib[NIB_BITS-1] != a_q[WIDTH-1]);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
